// File: rtl/ifm_rd_pkg.sv
// ifm_rd_rsp shared types and default geometry.
// IFM read responder: address/data widths and framing states.
package ifm_rd_pkg;

    localparam int IFM_AW = 14;
    localparam int IFM_DW = 8;
    localparam int IFM_DN = 8;
    localparam int IFM_FD = 4;

    typedef enum logic {
        RSP_IDLE,
        RSP_BURST
    } rsp_state_t;

endpackage

// File: rtl/ifm_rd_rsp_if.sv
// ifm_rd_rsp bus bundle: address stream, SRAM port, data stream.
// slave = responder side, master = DMA / SRAM model side.
interface ifm_rd_rsp_if
    import ifm_rd_pkg::*;
#(
    parameter int AW = IFM_AW,
    parameter int DW = IFM_DW,
    parameter int DN = IFM_DN
);
    logic [AW-1:0]    ifm_addr;
    logic             ifm_addr_first;
    logic             ifm_addr_last;
    logic             ifm_addr_valid;
    logic             ifm_addr_ready;
    logic             mem_en;
    logic [AW-1:0]    mem_addr;
    logic [DN*DW-1:0] mem_rdata;
    logic [DN*DW-1:0] rd_data;
    logic             rd_first;
    logic             rd_last;
    logic             rd_valid;
    logic             rd_ready;
    logic             burst_done;
    logic             proto_err;
    logic             err_clr;

    modport slave (
        input  ifm_addr, ifm_addr_first, ifm_addr_last, ifm_addr_valid,
        output ifm_addr_ready,
        output mem_en, mem_addr,
        input  mem_rdata,
        output rd_data, rd_first, rd_last, rd_valid,
        input  rd_ready,
        output burst_done, proto_err,
        input  err_clr
    );

    modport master (
        output ifm_addr, ifm_addr_first, ifm_addr_last, ifm_addr_valid,
        input  ifm_addr_ready,
        input  mem_en, mem_addr,
        output mem_rdata,
        input  rd_data, rd_first, rd_last, rd_valid,
        output rd_ready,
        input  burst_done, proto_err,
        output err_clr
    );

endinterface

// File: rtl/ifm_rsp_fifo.sv
// Shift-register FIFO; entry 0 is the registered head.
// Writes land at the first free slot, pops shift everything down.
module ifm_rsp_fifo #(
    parameter  int W  = 66,
    parameter  int FD = 4,
    localparam int CW = $clog2(FD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  ent_q [FD];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] widx;

    // Occupancy update and write slot (slot shifts down on a pop).
    always_comb begin
        widx    = pop_i ? count_q - 1'b1 : count_q;
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage: the write wins over the shift for the slot it targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < FD; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < FD; i++) begin
                if (push_i && widx == CW'(i)) begin
                    ent_q[i] <= wdata_i;
                end else if (pop_i) begin
                    ent_q[i] <= ent_q[(i < FD - 1) ? i + 1 : i];
                end
            end
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/ifm_rd_rsp.sv
// IFM read responder: address beats -> SRAM reads -> in-order data words.
// Credit on FIFO occupancy plus the in-flight read keeps the FIFO from overflowing.
module ifm_rd_rsp
    import ifm_rd_pkg::*;
#(
    parameter  int AW = IFM_AW,
    parameter  int DW = IFM_DW,
    parameter  int DN = IFM_DN,
    parameter  int FD = IFM_FD,
    localparam int W  = DN * DW + 2,
    localparam int CW = $clog2(FD + 1)
) (
    input logic         clk,
    input logic         rst_n,
    ifm_rd_rsp_if.slave bus
);

    logic            acc;
    logic            pop;
    logic            rd_valid;
    logic            infl_q;
    logic            first_q;
    logic            last_q;
    logic            burst_done_q;
    logic            proto_err_q;
    logic            err_set;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic [W-1:0]    head;
    logic [AW-1:0]   addr_w;
    logic [DN*DW-1:0] rdata_w;
    rsp_state_t      state_q;
    rsp_state_t      state_d;

    assign credit = {1'b0, count} + {{CW{1'b0}}, infl_q};
    assign bus.ifm_addr_ready = credit < (CW + 1)'(FD);
    assign acc = bus.ifm_addr_valid && bus.ifm_addr_ready;

    assign addr_w       = bus.ifm_addr;
    assign bus.mem_en   = acc;
    assign bus.mem_addr = addr_w;
    assign rdata_w      = bus.mem_rdata;

    // Track the one read in flight and the tags that travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            infl_q <= acc;
            if (acc) begin
                first_q <= bus.ifm_addr_first;
                last_q  <= bus.ifm_addr_last;
            end
        end
    end

    ifm_rsp_fifo #(
        .W  (W),
        .FD (FD)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (infl_q),
        .wdata_i ({rdata_w, first_q, last_q}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign rd_valid     = count != '0;
    assign pop          = rd_valid && bus.rd_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = head[W-1:2];
    assign bus.rd_first = head[1];
    assign bus.rd_last  = head[0];

    // Framing decode: a last beat always closes the burst.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        if (acc) begin
            state_d = bus.ifm_addr_last ? RSP_IDLE : RSP_BURST;
            unique case (state_q)
                RSP_IDLE:  err_set = !bus.ifm_addr_first;
                RSP_BURST: err_set = bus.ifm_addr_first;
                default:   err_set = 1'b0;
            endcase
        end
    end

    // Framing FSM with sticky error; a new error beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RSP_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                proto_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                proto_err_q <= 1'b0;
            end
        end
    end

    // Burst completion pulse, one cycle after the last word leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= pop && head[0];
        end
    end

    assign bus.burst_done = burst_done_q;
    assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_ifm_rd_rsp.sv
// Bench for ifm_rd_rsp: SRAM model, scoreboard of accepted beats,
// directed latency/stream/backpressure/framing/reset scenarios.
module tb_ifm_rd_rsp;
    import ifm_rd_pkg::*;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int DN = 8;
    localparam int FD = 4;
    localparam int WD = DN * DW;

    typedef logic [WD+1:0] v_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ifm_rd_rsp_if #(.AW(AW), .DW(DW), .DN(DN)) bus();

    ifm_rd_rsp #(.AW(AW), .DW(DW), .DN(DN), .FD(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_pop   = 0;
    v_t sb_q[$];

    function automatic logic [WD-1:0] memf(logic [AW-1:0] a);
        return {16'hC0DE, 16'(a) ^ 16'h5A5A, 16'(a), 16'(a) + 16'h1111};
    endfunction

    task automatic check(string tag, v_t got, v_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SRAM model with 1-cycle latency; garbage when not enabled.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? memf(bus.mem_addr) : {4{16'hDEAD}};
    end

    logic hold_v = 1'b0;
    v_t   hold_w;
    logic bd_exp = 1'b0;

    // Scoreboard monitor: sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            hold_v = 1'b0;
            bd_exp = 1'b0;
        end else begin
            check("mem_en", v_t'(bus.mem_en),
                  v_t'(bus.ifm_addr_valid && bus.ifm_addr_ready));
            check("mem_addr", v_t'(bus.mem_addr), v_t'(bus.ifm_addr));
            check("burst_done", v_t'(bus.burst_done), v_t'(bd_exp));
            if (hold_v) begin
                check("hold_valid", v_t'(bus.rd_valid), v_t'(1));
                check("hold_word", {bus.rd_data, bus.rd_first, bus.rd_last}, hold_w);
            end
            if (bus.ifm_addr_valid && bus.ifm_addr_ready) begin
                sb_q.push_back({memf(bus.ifm_addr), bus.ifm_addr_first, bus.ifm_addr_last});
                n_acc++;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                check("sb_nonempty", v_t'(sb_q.size() != 0), v_t'(1));
                if (sb_q.size() != 0) begin
                    check("rd_word", {bus.rd_data, bus.rd_first, bus.rd_last}, sb_q.pop_front());
                end
                n_pop++;
            end
            bd_exp = bus.rd_valid && bus.rd_ready && bus.rd_last;
            hold_v = bus.rd_valid && !bus.rd_ready;
            hold_w = {bus.rd_data, bus.rd_first, bus.rd_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic [AW-1:0] a, logic f, logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.ifm_addr       = a;
        bus.ifm_addr_first = f;
        bus.ifm_addr_last  = l;
        bus.ifm_addr_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.ifm_addr_ready;
            tick();
            n++;
        end
        check("addr_accept", v_t'(ok), v_t'(1));
    endtask

    task automatic burst(logic [AW-1:0] base, int n);
        for (int i = 0; i < n; i++) begin
            beat(AW'(base + AW'(i)), i == 0, i == n - 1);
        end
        bus.ifm_addr_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.rd_valid) && k < 100) begin
            tick();
            k++;
        end
        check("drain", v_t'(sb_q.size()), v_t'(0));
        tick();
        tick();
    endtask

    logic bp_busy = 1'b0;
    int   p0;
    int   a0;
    int   k;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ifm_addr       = '0;
        bus.ifm_addr_first = 1'b0;
        bus.ifm_addr_last  = 1'b0;
        bus.ifm_addr_valid = 1'b0;
        bus.rd_ready       = 1'b1;
        bus.err_clr        = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", v_t'(bus.ifm_addr_ready), v_t'(1));
        check("rst_mem_en", v_t'(bus.mem_en), v_t'(0));
        check("rst_rd_valid", v_t'(bus.rd_valid), v_t'(0));
        check("rst_rd_data", v_t'(bus.rd_data), v_t'(0));
        check("rst_rd_first", v_t'(bus.rd_first), v_t'(0));
        check("rst_rd_last", v_t'(bus.rd_last), v_t'(0));
        check("rst_burst_done", v_t'(bus.burst_done), v_t'(0));
        check("rst_proto_err", v_t'(bus.proto_err), v_t'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // single-beat burst latency
        bus.ifm_addr       = 14'h0010;
        bus.ifm_addr_first = 1'b1;
        bus.ifm_addr_last  = 1'b1;
        bus.ifm_addr_valid = 1'b1;
        @(negedge clk);
        check("lat_mem_en", v_t'(bus.mem_en), v_t'(1));
        check("lat_mem_addr", v_t'(bus.mem_addr), v_t'(14'h0010));
        tick();
        bus.ifm_addr_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", v_t'(bus.rd_valid), v_t'(0));
        @(negedge clk);
        check("lat_t2_valid", v_t'(bus.rd_valid), v_t'(1));
        check("lat_t2_word", {bus.rd_data, bus.rd_first, bus.rd_last},
              {memf(14'h0010), 2'b11});
        @(negedge clk);
        check("lat_t3_done", v_t'(bus.burst_done), v_t'(1));
        drain();

        // 16-beat streaming burst, no gaps
        p0 = n_pop;
        for (int i = 0; i < 16; i++) begin
            bus.ifm_addr       = AW'(14'h0100 + AW'(i));
            bus.ifm_addr_first = (i == 0);
            bus.ifm_addr_last  = (i == 15);
            bus.ifm_addr_valid = 1'b1;
            @(negedge clk);
            check("strm_ready", v_t'(bus.ifm_addr_ready), v_t'(1));
            if (i >= 2) check("strm_gap", v_t'(bus.rd_valid), v_t'(1));
            tick();
        end
        bus.ifm_addr_valid = 1'b0;
        @(negedge clk);
        check("strm_tail14", v_t'(bus.rd_valid), v_t'(1));
        tick();
        @(negedge clk);
        check("strm_tail15", v_t'(bus.rd_valid), v_t'(1));
        tick();
        @(negedge clk);
        check("strm_end", v_t'(bus.rd_valid), v_t'(0));
        drain();
        check("strm_words", v_t'(n_pop - p0), v_t'(16));
        check("strm_err", v_t'(bus.proto_err), v_t'(0));

        // backpressure: 8-beat burst into a stalled consumer
        bus.rd_ready = 1'b0;
        a0 = n_acc;
        p0 = n_pop;
        bp_busy = 1'b1;
        fork
            begin
                burst(14'h0200, 8);
                bp_busy = 1'b0;
            end
        join_none
        repeat (12) tick();
        @(negedge clk);
        check("bp_accepted", v_t'(n_acc - a0), v_t'(4));
        check("bp_ready_low", v_t'(bus.ifm_addr_ready), v_t'(0));
        check("bp_full_valid", v_t'(bus.rd_valid), v_t'(1));
        tick();
        bus.rd_ready = 1'b1;
        k = 0;
        while (bp_busy && k < 200) begin
            tick();
            k++;
        end
        check("bp_finished", v_t'(bp_busy), v_t'(0));
        drain();
        check("bp_words", v_t'(n_pop - p0), v_t'(8));
        check("bp_beats", v_t'(n_acc - a0), v_t'(8));

        // framing errors
        p0 = n_pop;
        beat(14'h0300, 1'b0, 1'b1);
        bus.ifm_addr_valid = 1'b0;
        drain();
        check("err_idle", v_t'(bus.proto_err), v_t'(1));
        check("err_fwd", v_t'(n_pop - p0), v_t'(1));
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", v_t'(bus.proto_err), v_t'(0));
        tick();
        beat(14'h0310, 1'b1, 1'b0);
        bus.ifm_addr_valid = 1'b0;
        @(negedge clk);
        check("err_ok_start", v_t'(bus.proto_err), v_t'(0));
        tick();
        beat(14'h0311, 1'b1, 1'b0);
        beat(14'h0312, 1'b0, 1'b1);
        bus.ifm_addr_valid = 1'b0;
        @(negedge clk);
        check("err_mid_first", v_t'(bus.proto_err), v_t'(1));
        drain();

        // reset with words queued
        bus.rd_ready = 1'b0;
        beat(14'h0320, 1'b1, 1'b0);
        beat(14'h0321, 1'b0, 1'b0);
        beat(14'h0322, 1'b0, 1'b0);
        bus.ifm_addr_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rstm_queued", v_t'(sb_q.size()), v_t'(3));
        check("rstm_valid_pre", v_t'(bus.rd_valid), v_t'(1));
        tick();
        rst_n = 1'b0;
        #1;
        check("rstm_valid", v_t'(bus.rd_valid), v_t'(0));
        check("rstm_ready", v_t'(bus.ifm_addr_ready), v_t'(1));
        check("rstm_done", v_t'(bus.burst_done), v_t'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        bus.rd_ready = 1'b1;
        tick();
        check("rstm_err", v_t'(bus.proto_err), v_t'(0));
        p0 = n_pop;
        burst(14'h0400, 4);
        drain();
        check("rstm_words", v_t'(n_pop - p0), v_t'(4));
        check("rstm_err_end", v_t'(bus.proto_err), v_t'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
